// File: rtl/imem_noc_arbiter_2to1_if.sv
// Shared memory-bus types and the request/response port bundle used by the
// instruction-memory NoC arbiter.
//   req_valid/req_ready/req       : request handshake and payload
//   resp_valid/resp_ready/resp    : response handshake and payload (bursts end on resp_last)
// The "master" modport is the side that issues requests; "slave" answers them.

package urv_typedef;
  typedef struct packed {
    logic [31:0] addr;
  } mem_req_t;

  typedef struct packed {
    logic [31:0] data;
    logic        resp_last;
  } mem_resp_t;
endpackage

interface imem_noc_arbiter_2to1_if;
  import urv_typedef::*;

  logic      req_valid;
  logic      req_ready;
  mem_req_t  req;
  logic      resp_valid;
  logic      resp_ready;
  mem_resp_t resp;

  modport master (
    output req_valid, req, resp_ready,
    input  req_ready, resp_valid, resp
  );

  modport slave (
    input  req_valid, req, resp_ready,
    output req_ready, resp_valid, resp
  );
endinterface

// File: rtl/imem_noc_arbiter_2to1.sv
// Two-master to one-slave arbiter for the instruction-memory NoC.
// One transaction is outstanding at a time; each response burst is steered
// back to the master that issued the request. Both paths are combinational,
// only the arbitration/ownership state is registered.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   m0, m1   : slave-side bundles facing the two fetch masters
//   sn       : master-side bundle facing the memory slave
//   sn_mid   : id of the master currently presented on sn.req
// Parameters:
//   RR_EN    : 1 = round-robin on contention, 0 = m0 always wins
//   RST_PTR  : master preferred first after reset (round-robin only)

module imem_noc_arbiter_2to1 #(
  parameter bit RR_EN   = 1'b1,
  parameter bit RST_PTR = 1'b0
) (
  input  logic                          clk,
  input  logic                          rst,
  imem_noc_arbiter_2to1_if.slave        m0,
  imem_noc_arbiter_2to1_if.slave        m1,
  imem_noc_arbiter_2to1_if.master       sn,
  output logic                          sn_mid
);

  typedef enum logic [0:0] {
    ARB  = 1'b0,
    RESP = 1'b1
  } st_e;

  st_e  st_r, st_n;
  logic owner_r, owner_n;
  logic rr_ptr_r, rr_ptr_n;
  logic lock_r, lock_n;
  logic lock_id_r, lock_id_n;

  logic sel_s;
  logic sel_valid_s;
  logic in_resp_s;
  logic sn_resp_ready_s;
  logic last_hs_s;
  logic acc_s;
  logic sn_req_valid_s;
  logic req_hs_s;

  // Master selection: a stalled grant stays locked, otherwise single requester
  // wins, contention resolved by pointer (round-robin) or to m0 (fixed).
  always_comb begin
    sel_s = 1'b0;
    if (lock_r) begin
      sel_s = lock_id_r;
    end else if (m0.req_valid && !m1.req_valid) begin
      sel_s = 1'b0;
    end else if (!m0.req_valid && m1.req_valid) begin
      sel_s = 1'b1;
    end else if (m0.req_valid && m1.req_valid) begin
      sel_s = RR_EN ? rr_ptr_r : 1'b0;
    end else begin
      sel_s = 1'b0;
    end
  end

  // Handshake qualifiers; everything is forced low while rst is held so the
  // outputs drop immediately on an asynchronous reset.
  assign in_resp_s       = !rst && (st_r == RESP);
  assign sn_resp_ready_s = in_resp_s && (owner_r ? m1.resp_ready : m0.resp_ready);
  assign last_hs_s       = sn_resp_ready_s && sn.resp_valid && sn.resp.resp_last;
  // A new request may go out in the same cycle the final beat completes.
  assign acc_s           = !rst && ((st_r == ARB) || last_hs_s);
  assign sel_valid_s     = sel_s ? m1.req_valid : m0.req_valid;
  assign sn_req_valid_s  = acc_s && sel_valid_s;
  assign req_hs_s        = sn_req_valid_s && sn.req_ready;

  // Request path
  assign sn.req_valid = sn_req_valid_s;
  assign sn.req       = sel_s ? m1.req : m0.req;
  assign sn_mid       = rst ? 1'b0 : sel_s;
  assign m0.req_ready = acc_s && !sel_s && sn.req_ready;
  assign m1.req_ready = acc_s &&  sel_s && sn.req_ready;

  // Response path: payload is broadcast, valid selects the owner.
  assign m0.resp       = sn.resp;
  assign m1.resp       = sn.resp;
  assign m0.resp_valid = in_resp_s && !owner_r && sn.resp_valid;
  assign m1.resp_valid = in_resp_s &&  owner_r && sn.resp_valid;
  assign sn.resp_ready = sn_resp_ready_s;

  // Next-state logic for phase, owner, round-robin pointer and grant lock.
  always_comb begin
    st_n      = st_r;
    owner_n   = owner_r;
    rr_ptr_n  = rr_ptr_r;
    lock_n    = 1'b0;
    lock_id_n = lock_id_r;

    // Hold a stalled grant; the lock naturally drops on handshake or if the
    // locked master withdraws its request.
    if (sn_req_valid_s && !sn.req_ready) begin
      lock_n    = 1'b1;
      lock_id_n = sel_s;
    end else begin
      lock_n    = 1'b0;
    end

    case (st_r)
      ARB: begin
        if (req_hs_s) begin
          st_n    = RESP;
          owner_n = sel_s;
          if (RR_EN) begin
            rr_ptr_n = ~sel_s;
          end else begin
            rr_ptr_n = rr_ptr_r;
          end
        end else begin
          st_n = ARB;
        end
      end
      RESP: begin
        if (req_hs_s) begin
          // Back-to-back: new grant overlaps the final beat, no bubble.
          st_n    = RESP;
          owner_n = sel_s;
          if (RR_EN) begin
            rr_ptr_n = ~sel_s;
          end else begin
            rr_ptr_n = rr_ptr_r;
          end
        end else if (last_hs_s) begin
          st_n = ARB;
        end else begin
          st_n = RESP;
        end
      end
      default: begin
        st_n = ARB;
      end
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_r      <= ARB;
      owner_r   <= 1'b0;
      rr_ptr_r  <= RST_PTR;
      lock_r    <= 1'b0;
      lock_id_r <= 1'b0;
    end else begin
      st_r      <= st_n;
      owner_r   <= owner_n;
      rr_ptr_r  <= rr_ptr_n;
      lock_r    <= lock_n;
      lock_id_r <= lock_id_n;
    end
  end

endmodule

// File: tb/tb_imem_noc_arbiter_2to1.sv
// Self-checking bench for imem_noc_arbiter_2to1: directed scenarios plus a
// randomized contention run checked against a transaction-level model.
module tb_imem_noc_arbiter_2to1;
  import urv_typedef::*;

  logic clk;
  logic rst;
  logic mid_i;
  logic mid_f;
  int   errors = 0;
  int   checks = 0;

  imem_noc_arbiter_2to1_if i_m0();
  imem_noc_arbiter_2to1_if i_m1();
  imem_noc_arbiter_2to1_if i_sn();
  imem_noc_arbiter_2to1_if f_m0();
  imem_noc_arbiter_2to1_if f_m1();
  imem_noc_arbiter_2to1_if f_sn();

  imem_noc_arbiter_2to1 #(.RR_EN(1'b1), .RST_PTR(1'b0)) dut (
    .clk(clk), .rst(rst), .m0(i_m0), .m1(i_m1), .sn(i_sn), .sn_mid(mid_i)
  );

  imem_noc_arbiter_2to1 #(.RR_EN(1'b0), .RST_PTR(1'b0)) dut_fp (
    .clk(clk), .rst(rst), .m0(f_m0), .m1(f_m1), .sn(f_sn), .sn_mid(mid_f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    i_m0.req_valid = 1'b0; i_m0.req = '0; i_m0.resp_ready = 1'b0;
    i_m1.req_valid = 1'b0; i_m1.req = '0; i_m1.resp_ready = 1'b0;
    i_sn.req_ready = 1'b0; i_sn.resp_valid = 1'b0; i_sn.resp = '0;
    f_m0.req_valid = 1'b0; f_m0.req = '0; f_m0.resp_ready = 1'b0;
    f_m1.req_valid = 1'b0; f_m1.req = '0; f_m1.resp_ready = 1'b0;
    f_sn.req_ready = 1'b0; f_sn.resp_valid = 1'b0; f_sn.resp = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_all();
    i_m0.req_valid = 1'b1; i_sn.req_ready = 1'b1;
    i_sn.resp_valid = 1'b1; i_m0.resp_ready = 1'b1;
    tick(); tick();
    checks++; if (i_sn.req_valid !== 1'b0) begin errors++; $display("FAIL reset_sn_req_valid: got %b want 0", i_sn.req_valid); end
    checks++; if (i_m0.req_ready !== 1'b0) begin errors++; $display("FAIL reset_m0_req_ready: got %b want 0", i_m0.req_ready); end
    checks++; if (i_sn.resp_ready !== 1'b0) begin errors++; $display("FAIL reset_sn_resp_ready: got %b want 0", i_sn.resp_ready); end
    checks++; if (i_m0.resp_valid !== 1'b0) begin errors++; $display("FAIL reset_m0_resp_valid: got %b want 0", i_m0.resp_valid); end
    checks++; if (mid_i !== 1'b0) begin errors++; $display("FAIL reset_sn_mid: got %b want 0", mid_i); end
    idle_all();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    idle_all();
    i_m0.req_valid = 1'b1; i_m0.req.addr = 32'h0000_0100; i_sn.req_ready = 1'b1;
    #1;
    checks++; if (i_sn.req_valid !== 1'b1) begin errors++; $display("FAIL single_sn_req_valid: got %b want 1", i_sn.req_valid); end
    checks++; if (mid_i !== 1'b0) begin errors++; $display("FAIL single_sn_mid: got %b want 0", mid_i); end
    checks++; if (i_m0.req_ready !== 1'b1) begin errors++; $display("FAIL single_m0_req_ready: got %b want 1", i_m0.req_ready); end
    checks++; if (i_m1.req_ready !== 1'b0) begin errors++; $display("FAIL single_m1_req_ready: got %b want 0", i_m1.req_ready); end
    checks++; if (i_sn.req.addr !== 32'h0000_0100) begin errors++; $display("FAIL single_sn_req_addr: got %h want 00000100", i_sn.req.addr); end
    tick();
    i_m0.req_valid = 1'b0; i_m0.resp_ready = 1'b1;
    i_sn.resp_valid = 1'b1; i_sn.resp.data = 32'hAAAA_0001; i_sn.resp.resp_last = 1'b0;
    #1;
    checks++; if (i_m0.resp_valid !== 1'b1) begin errors++; $display("FAIL single_beat0_m0_valid: got %b want 1", i_m0.resp_valid); end
    checks++; if (i_m1.resp_valid !== 1'b0) begin errors++; $display("FAIL single_beat0_m1_valid: got %b want 0", i_m1.resp_valid); end
    checks++; if (i_m0.resp.data !== 32'hAAAA_0001) begin errors++; $display("FAIL single_beat0_data: got %h want aaaa0001", i_m0.resp.data); end
    tick();
    i_sn.resp.data = 32'hAAAA_0002; i_sn.resp.resp_last = 1'b1;
    #1;
    checks++; if (i_m0.resp_valid !== 1'b1) begin errors++; $display("FAIL single_beat1_m0_valid: got %b want 1", i_m0.resp_valid); end
    checks++; if (i_sn.resp_ready !== 1'b1) begin errors++; $display("FAIL single_beat1_sn_ready: got %b want 1", i_sn.resp_ready); end
    checks++; if (i_m1.resp_valid !== 1'b0) begin errors++; $display("FAIL single_beat1_m1_valid: got %b want 0", i_m1.resp_valid); end
    tick();
    // Stray beat while idle must be held off.
    #1;
    checks++; if (i_sn.resp_ready !== 1'b0) begin errors++; $display("FAIL stray_sn_resp_ready: got %b want 0", i_sn.resp_ready); end
    checks++; if ({i_m0.resp_valid, i_m1.resp_valid} !== 2'b00) begin errors++; $display("FAIL stray_resp_valids: got %b want 00", {i_m0.resp_valid, i_m1.resp_valid}); end
    idle_all();
    tick();
  endtask

  task automatic test_back_to_back();
    idle_all();
    i_m0.req_valid = 1'b1; i_m0.req.addr = 32'h0000_0400; i_sn.req_ready = 1'b1;
    #1;
    checks++; if (i_m0.req_ready !== 1'b1) begin errors++; $display("FAIL b2b_m0_req_ready: got %b want 1", i_m0.req_ready); end
    tick();
    i_m0.req_valid = 1'b0; i_m1.req_valid = 1'b1; i_m1.req.addr = 32'h0000_0500;
    i_m0.resp_ready = 1'b1; i_sn.resp_valid = 1'b1; i_sn.resp.resp_last = 1'b0;
    #1;
    checks++; if (i_m1.req_ready !== 1'b0) begin errors++; $display("FAIL b2b_midburst_m1_ready: got %b want 0", i_m1.req_ready); end
    checks++; if (i_sn.req_valid !== 1'b0) begin errors++; $display("FAIL b2b_midburst_sn_valid: got %b want 0", i_sn.req_valid); end
    tick();
    i_sn.resp.resp_last = 1'b1;
    #1;
    checks++; if (i_m1.req_ready !== 1'b1) begin errors++; $display("FAIL b2b_last_m1_ready: got %b want 1", i_m1.req_ready); end
    checks++; if (mid_i !== 1'b1) begin errors++; $display("FAIL b2b_last_sn_mid: got %b want 1", mid_i); end
    checks++; if (i_m0.resp_valid !== 1'b1) begin errors++; $display("FAIL b2b_last_m0_valid: got %b want 1", i_m0.resp_valid); end
    tick();
    i_m1.req_valid = 1'b0; i_m1.resp_ready = 1'b1; i_sn.resp.data = 32'h5555_0000;
    #1;
    checks++; if (i_m1.resp_valid !== 1'b1) begin errors++; $display("FAIL b2b_next_m1_valid: got %b want 1", i_m1.resp_valid); end
    checks++; if (i_m0.resp_valid !== 1'b0) begin errors++; $display("FAIL b2b_next_m0_valid: got %b want 0", i_m0.resp_valid); end
    tick();
    #1;
    checks++; if (i_sn.resp_ready !== 1'b0) begin errors++; $display("FAIL b2b_back_to_arb: got %b want 0", i_sn.resp_ready); end
    idle_all();
    tick();
  endtask

  task automatic test_grant_hold();
    // Pointer now favours m0, so only the lock keeps m1 on the bus.
    idle_all();
    i_m1.req_valid = 1'b1; i_m1.req.addr = 32'h0000_0200;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) begin
        i_m0.req_valid = 1'b1; i_m0.req.addr = 32'h0000_0300;
      end
      #1;
      checks++; if (mid_i !== 1'b1) begin errors++; $display("FAIL hold_sn_mid c%0d: got %b want 1", c, mid_i); end
      checks++; if (i_sn.req.addr !== 32'h0000_0200) begin errors++; $display("FAIL hold_sn_req c%0d: got %h want 00000200", c, i_sn.req.addr); end
      checks++; if (i_m0.req_ready !== 1'b0) begin errors++; $display("FAIL hold_m0_ready c%0d: got %b want 0", c, i_m0.req_ready); end
      tick();
    end
    i_sn.req_ready = 1'b1;
    #1;
    checks++; if (i_m1.req_ready !== 1'b1) begin errors++; $display("FAIL hold_m1_hs: got %b want 1", i_m1.req_ready); end
    checks++; if (i_m0.req_ready !== 1'b0) begin errors++; $display("FAIL hold_m0_hs: got %b want 0", i_m0.req_ready); end
    tick();
    i_m0.req_valid = 1'b0; i_m1.req_valid = 1'b0; i_m1.resp_ready = 1'b1;
    i_sn.resp_valid = 1'b1; i_sn.resp.resp_last = 1'b1;
    #1;
    checks++; if ({i_m1.resp_valid, i_m0.resp_valid} !== 2'b10) begin errors++; $display("FAIL hold_resp_route: got %b want 10", {i_m1.resp_valid, i_m0.resp_valid}); end
    tick();
    idle_all();
    tick();
  endtask

  task automatic test_backpressure();
    idle_all();
    i_m0.req_valid = 1'b1; i_sn.req_ready = 1'b1;
    tick();
    i_m0.req_valid = 1'b0; i_sn.resp_valid = 1'b1; i_sn.resp.resp_last = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++; if (i_sn.resp_ready !== 1'b0) begin errors++; $display("FAIL bp_sn_ready c%0d: got %b want 0", c, i_sn.resp_ready); end
      checks++; if (i_m0.resp_valid !== 1'b1) begin errors++; $display("FAIL bp_m0_valid c%0d: got %b want 1", c, i_m0.resp_valid); end
      tick();
    end
    i_m0.resp_ready = 1'b1;
    #1;
    checks++; if (i_sn.resp_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got %b want 1", i_sn.resp_ready); end
    tick();
    idle_all();
    tick();
  endtask

  task automatic test_reset_midburst();
    idle_all();
    i_m1.req_valid = 1'b1; i_sn.req_ready = 1'b1;
    tick();
    i_m0.req_valid = 1'b1; i_m1.resp_ready = 1'b1; i_m0.resp_ready = 1'b1;
    i_sn.resp_valid = 1'b1; i_sn.resp.resp_last = 1'b0;
    f_m0.req_valid = 1'b1; f_sn.req_ready = 1'b1;
    #1;
    checks++; if (i_m1.resp_valid !== 1'b1) begin errors++; $display("FAIL rstmid_pre_owner1: got %b want 1", i_m1.resp_valid); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if ({i_sn.req_valid, i_m0.req_ready, i_m1.req_ready} !== 3'b000) begin errors++; $display("FAIL rstmid_req_side: got %b want 000", {i_sn.req_valid, i_m0.req_ready, i_m1.req_ready}); end
    checks++; if ({i_sn.resp_ready, i_m0.resp_valid, i_m1.resp_valid} !== 3'b000) begin errors++; $display("FAIL rstmid_resp_side: got %b want 000", {i_sn.resp_ready, i_m0.resp_valid, i_m1.resp_valid}); end
    checks++; if (mid_i !== 1'b0) begin errors++; $display("FAIL rstmid_sn_mid: got %b want 0", mid_i); end
    checks++; if ({f_sn.req_valid, f_m0.req_ready} !== 2'b00) begin errors++; $display("FAIL rstmid_fp_req: got %b want 00", {f_sn.req_valid, f_m0.req_ready}); end
    tick();
    i_m0.req_valid = 1'b0; i_m1.req_valid = 1'b0; f_m0.req_valid = 1'b0;
    rst = 1'b0;
    #1;
    checks++; if (i_sn.resp_ready !== 1'b0) begin errors++; $display("FAIL rstmid_leftover_held: got %b want 0", i_sn.resp_ready); end
    checks++; if (i_m1.resp_valid !== 1'b0) begin errors++; $display("FAIL rstmid_leftover_m1: got %b want 0", i_m1.resp_valid); end
    idle_all();
    tick();
  endtask

  task automatic test_fixed_priority();
    idle_all();
    f_m0.req_valid = 1'b1; f_m1.req_valid = 1'b1; f_sn.req_ready = 1'b1;
    f_m0.req.addr = 32'h0000_0A00; f_m1.req.addr = 32'h0000_0B00;
    #1;
    checks++; if (mid_f !== 1'b0) begin errors++; $display("FAIL fp_first_mid: got %b want 0", mid_f); end
    checks++; if ({f_m0.req_ready, f_m1.req_ready} !== 2'b10) begin errors++; $display("FAIL fp_first_ready: got %b want 10", {f_m0.req_ready, f_m1.req_ready}); end
    checks++; if (f_sn.req.addr !== 32'h0000_0A00) begin errors++; $display("FAIL fp_first_addr: got %h want 00000a00", f_sn.req.addr); end
    tick();
    f_m0.resp_ready = 1'b1; f_sn.resp_valid = 1'b1; f_sn.resp.resp_last = 1'b1;
    #1;
    checks++; if ({f_m0.req_ready, f_m1.req_ready} !== 2'b10) begin errors++; $display("FAIL fp_second_ready: got %b want 10", {f_m0.req_ready, f_m1.req_ready}); end
    checks++; if (f_m0.resp_valid !== 1'b1) begin errors++; $display("FAIL fp_resp_m0: got %b want 1", f_m0.resp_valid); end
    tick();
    f_m0.req_valid = 1'b0; f_m1.req_valid = 1'b0;
    tick();
    idle_all();
    tick();
  endtask

  // Both masters request continuously; grants must alternate starting at
  // m0, and every beat must reach only the master that owns the burst.
  task automatic test_contention_random();
    int   n = 0;
    int   beats_left = 0;
    bit   busy = 1'b0;
    bit   owner = 1'b0;
    bit   exp_sel, rr0, rr1, exp_srr, done, acc;
    logic [31:0] a0, a1;
    idle_all();
    a0 = $urandom; a1 = $urandom;
    for (int cyc = 0; cyc < 200; cyc++) begin
      i_m0.req_valid = 1'b1; i_m1.req_valid = 1'b1;
      i_m0.req.addr = a0; i_m1.req.addr = a1;
      i_sn.req_ready = ($urandom_range(0, 3) != 0);
      rr0 = ($urandom_range(0, 3) != 0);
      rr1 = ($urandom_range(0, 3) != 0);
      i_m0.resp_ready = rr0; i_m1.resp_ready = rr1;
      i_sn.resp.data = $urandom;
      if (busy) begin
        i_sn.resp_valid = ($urandom_range(0, 2) != 0);
        i_sn.resp.resp_last = (beats_left == 1);
      end else begin
        i_sn.resp_valid = ($urandom_range(0, 3) == 0);
        i_sn.resp.resp_last = ($urandom_range(0, 1) == 1);
      end
      #1;
      exp_sel = n[0];
      exp_srr = busy && (owner ? rr1 : rr0);
      done    = exp_srr && i_sn.resp_valid && (beats_left == 1);
      acc     = !busy || done;
      checks++; if (i_m0.resp_valid !== (busy && !owner && i_sn.resp_valid)) begin errors++; $display("FAIL rnd_m0_resp_valid cyc%0d: got %b want %b", cyc, i_m0.resp_valid, busy && !owner && i_sn.resp_valid); end
      checks++; if (i_m1.resp_valid !== (busy && owner && i_sn.resp_valid)) begin errors++; $display("FAIL rnd_m1_resp_valid cyc%0d: got %b want %b", cyc, i_m1.resp_valid, busy && owner && i_sn.resp_valid); end
      checks++; if (i_sn.resp_ready !== exp_srr) begin errors++; $display("FAIL rnd_sn_resp_ready cyc%0d: got %b want %b", cyc, i_sn.resp_ready, exp_srr); end
      checks++; if (i_sn.req_valid !== acc) begin errors++; $display("FAIL rnd_sn_req_valid cyc%0d: got %b want %b", cyc, i_sn.req_valid, acc); end
      checks++; if (i_m0.req_ready !== (acc && !exp_sel && i_sn.req_ready)) begin errors++; $display("FAIL rnd_m0_req_ready cyc%0d: got %b want %b", cyc, i_m0.req_ready, acc && !exp_sel && i_sn.req_ready); end
      checks++; if (i_m1.req_ready !== (acc && exp_sel && i_sn.req_ready)) begin errors++; $display("FAIL rnd_m1_req_ready cyc%0d: got %b want %b", cyc, i_m1.req_ready, acc && exp_sel && i_sn.req_ready); end
      checks++; if (mid_i !== exp_sel) begin errors++; $display("FAIL rnd_sn_mid cyc%0d: got %b want %b", cyc, mid_i, exp_sel); end
      checks++; if (i_sn.req.addr !== (exp_sel ? a1 : a0)) begin errors++; $display("FAIL rnd_sn_req_addr cyc%0d: got %h want %h", cyc, i_sn.req.addr, exp_sel ? a1 : a0); end
      if (busy && i_sn.resp_valid && exp_srr) begin
        beats_left--;
        if (beats_left == 0) busy = 1'b0;
      end
      if (acc && i_sn.req_ready) begin
        owner = exp_sel;
        busy = 1'b1;
        beats_left = $urandom_range(1, 3);
        n++;
        if (exp_sel) a1 = $urandom;
        else a0 = $urandom;
      end
      tick();
    end
    checks++; if (n < 4) begin errors++; $display("FAIL rnd_grant_count: got %0d want >=4", n); end
    idle_all();
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_grant_hold();
    test_backpressure();
    test_reset_midburst();
    test_fixed_priority();
    test_contention_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
